// File: rtl/pe_stu_pkg.sv
// Shared types for the PE -> stack-bus upstream packetizer: framing codes,
// packet type, the upstream beat layout and the packetizer FSM states.
package pe_stu_pkg;

    // Default geometry of the upstream beat.
    localparam int STU_WORD_W = 32;
    localparam int STU_DATA_W = 2 * STU_WORD_W;
    localparam int STU_OOB_W  = 16;

    // Upstream framing: bit 1 marks end of message, bit 0 marks start.
    typedef enum logic [1:0] {
        CNTL_MOM     = 2'b00,
        CNTL_SOM     = 2'b01,
        CNTL_EOM     = 2'b10,
        CNTL_SOM_EOM = 2'b11
    } cntl_e;

    // Packet type travels through unchanged; the values are opaque here.
    typedef enum logic [1:0] {
        STU_TYPE_0 = 2'd0,
        STU_TYPE_1 = 2'd1,
        STU_TYPE_2 = 2'd2,
        STU_TYPE_3 = 2'd3
    } stu_type_e;

    // One upstream beat as stored in the beat FIFO.
    typedef struct packed {
        cntl_e                  cntl;
        stu_type_e              typ;
        logic [STU_DATA_W-1:0]  data;
        logic [STU_OOB_W-1:0]   oob;
    } beat_t;

    // IDLE: between packets. EVEN: in packet, nothing held.
    // ODD: low word held. DRAIN: overrun, discarding until last.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVEN  = 2'd1,
        ST_ODD   = 2'd2,
        ST_DRAIN = 2'd3
    } pkt_state_e;

    // Build the framing code from start/end-of-message flags.
    function automatic cntl_e frame_cntl(input logic som, input logic eom);
        return cntl_e'({eom, som});
    endfunction

endpackage

// File: rtl/pe_stu_beat_fifo.sv
// Generic synchronous FIFO. The read port comes straight from storage flops,
// so a word pushed in cycle t is visible at the head in cycle t+1 and stays
// stable until popped. Push is ignored when full, pop ignored when empty.
module pe_stu_beat_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Head of queue; forced to zero while empty so outputs read 0 out of reset.
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // NOTE: storage flops carry no reset; only pointers and count are reset,
    // and the read port is masked while empty, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values,
    // independent of statement order within or across blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pe_stu_packetizer.sv
// Packs 32-bit PE result words pairwise into 64-bit stack-bus upstream beats,
// frames them SOM/MOM/EOM with type and {tag, half} out-of-band data, and
// queues them in a small beat FIFO under upstream back-pressure. Packets longer
// than MAX_BEATS beats are cut with a forced EOM, the tail is drained, and a
// sticky error is raised.
module pe_stu_packetizer
    import pe_stu_pkg::*;
#(
    parameter int WORD_W     = STU_WORD_W,
    parameter int DATA_W     = STU_DATA_W,
    parameter int OOB_W      = STU_OOB_W,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BEATS  = 64
) (
    input  logic              clk,
    input  logic              reset_poweron_n,
    input  logic              sop__pkt__valid,
    input  logic [WORD_W-1:0] sop__pkt__data,
    input  logic              sop__pkt__last,
    input  logic [1:0]        sop__pkt__type,
    input  logic [OOB_W-2:0]  sop__pkt__tag,
    output logic              pkt__sop__ready,
    output logic              pe__stu__valid,
    output logic [1:0]        pe__stu__cntl,
    output logic [1:0]        pe__stu__type,
    output logic [DATA_W-1:0] pe__stu__data,
    output logic [OOB_W-1:0]  pe__stu__oob_data,
    input  logic              stu__pe__ready,
    input  logic              sys__pkt__clear_error,
    output logic              pkt__sys__error,
    output logic              pkt__sys__idle
);

    // One spare bit so beat number MAX_BEATS itself is representable.
    localparam int CNT_W = $clog2(MAX_BEATS) + 1;

    pkt_state_e        state_q, state_d;
    logic [WORD_W-1:0] held_q, held_d;
    stu_type_e         type_q, type_d;
    logic [OOB_W-2:0]  tag_q, tag_d;
    logic              first_q, first_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              error_q, error_d;

    logic              accept;
    logic              in_first;
    logic              push;
    logic              half;
    logic              overrun;
    logic [DATA_W-1:0] push_data;
    logic [CNT_W-1:0]  beat_num;
    stu_type_e         cur_type;
    logic [OOB_W-2:0]  cur_tag;
    beat_t             push_beat;
    beat_t             pop_beat;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    // Word handshake. Ready drops whenever the FIFO is full, even if the next
    // word would only be held; DRAIN never pushes so it always accepts.
    assign pkt__sop__ready = !fifo_full || (state_q == ST_DRAIN);
    assign accept          = sop__pkt__valid && pkt__sop__ready;

    // The first word of a packet arrives in IDLE; type/tag are taken live then.
    assign in_first = (state_q == ST_IDLE) || first_q;
    assign cur_type = (state_q == ST_IDLE) ? stu_type_e'(sop__pkt__type) : type_q;
    assign cur_tag  = (state_q == ST_IDLE) ? sop__pkt__tag : tag_q;

    // beat_cnt_q is zero in IDLE, so this is the 1-based number of a push now.
    assign beat_num = beat_cnt_q + CNT_W'(1);
    assign overrun  = push && !sop__pkt__last && (beat_num == CNT_W'(MAX_BEATS));

    // FSM state register.
    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: pairing words, closing packets, entering/leaving DRAIN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && !sop__pkt__last) state_d = ST_ODD;
            end
            ST_EVEN: begin
                if (accept) state_d = sop__pkt__last ? ST_IDLE : ST_ODD;
            end
            ST_ODD: begin
                if (accept) begin
                    if (overrun)             state_d = ST_DRAIN;
                    else if (sop__pkt__last) state_d = ST_IDLE;
                    else                     state_d = ST_EVEN;
                end
            end
            ST_DRAIN: begin
                if (accept && sop__pkt__last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: when to push a beat and what goes in it.
    always_comb begin
        // NOTE: every variable gets a default at the top of the block so no
        // path leaves it unassigned, which would otherwise infer a latch.
        push      = 1'b0;
        half      = 1'b0;
        push_data = '0;
        unique case (state_q)
            ST_IDLE, ST_EVEN: begin
                if (accept && sop__pkt__last) begin
                    push      = 1'b1;
                    half      = 1'b1;
                    push_data = {{WORD_W{1'b0}}, sop__pkt__data};
                end
            end
            ST_ODD: begin
                if (accept) begin
                    push      = 1'b1;
                    push_data = {sop__pkt__data, held_q};
                end
            end
            default: ;
        endcase
    end

    // Assemble the beat; an overrun forces the end-of-message marker.
    always_comb begin
        push_beat.cntl = frame_cntl(in_first, sop__pkt__last || overrun);
        push_beat.typ  = cur_type;
        push_beat.data = push_data;
        push_beat.oob  = {cur_tag, half};
    end

    // Datapath next-state: held word, packet attributes, beat count, error.
    always_comb begin
        held_d     = held_q;
        type_d     = type_q;
        tag_d      = tag_q;
        first_d    = first_q;
        beat_cnt_d = beat_cnt_q;
        error_d    = error_q;

        if (accept && (state_q == ST_IDLE)) begin
            type_d  = stu_type_e'(sop__pkt__type);
            tag_d   = sop__pkt__tag;
            first_d = 1'b1;
        end
        if (accept && !sop__pkt__last && ((state_q == ST_IDLE) || (state_q == ST_EVEN))) begin
            held_d = sop__pkt__data;
        end
        if (push) begin
            first_d    = 1'b0;
            beat_cnt_d = beat_num;
        end
        if (state_d == ST_IDLE) begin
            beat_cnt_d = '0;
        end

        // A new overrun outranks a clear arriving in the same cycle.
        if (overrun) begin
            error_d = 1'b1;
        end else if (sys__pkt__clear_error) begin
            error_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            held_q     <= '0;
            type_q     <= STU_TYPE_0;
            tag_q      <= '0;
            first_q    <= 1'b0;
            beat_cnt_q <= '0;
            error_q    <= 1'b0;
        end else begin
            held_q     <= held_d;
            type_q     <= type_d;
            tag_q      <= tag_d;
            first_q    <= first_d;
            beat_cnt_q <= beat_cnt_d;
            error_q    <= error_d;
        end
    end

    // Beat FIFO between the packer and the upstream port.
    pe_stu_beat_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(beat_t))
    ) u_beat_fifo (
        .clk         (clk),
        .rst_n       (reset_poweron_n),
        .push_i      (push),
        .push_data_i (push_beat),
        .pop_i       (pop),
        .pop_data_o  (pop_beat),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign pop = pe__stu__valid && stu__pe__ready;

    // Upstream port driven directly from the FIFO head.
    assign pe__stu__valid    = !fifo_empty;
    assign pe__stu__cntl     = pop_beat.cntl;
    assign pe__stu__type     = pop_beat.typ;
    assign pe__stu__data     = pop_beat.data;
    assign pe__stu__oob_data = pop_beat.oob;

    assign pkt__sys__error = error_q;
    assign pkt__sys__idle  = (state_q == ST_IDLE) && fifo_empty;

endmodule

// File: tb/tb_pe_stu_packetizer.sv
// Self-checking bench for pe_stu_packetizer. Expected beats come from a
// packet-level model (pair words, cap at MAX_B beats) held in a queue.
`timescale 1ns/1ps
module tb_pe_stu_packetizer;

    localparam int MAX_B = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_poweron_n;
    logic        sop_valid;
    logic [31:0] sop_data;
    logic        sop_last;
    logic [1:0]  sop_type;
    logic [14:0] sop_tag;
    logic        sop_ready;
    logic        stu_valid;
    logic [1:0]  stu_cntl;
    logic [1:0]  stu_type;
    logic [63:0] stu_data;
    logic [15:0] stu_oob;
    logic        stu_ready;
    logic        clear_err;
    logic        sys_err;
    logic        sys_idle;

    logic        bp_mode;
    logic        forced_ready;
    logic        bp_rand = 1'b1;
    assign stu_ready = bp_mode ? bp_rand : forced_ready;

    always begin
        @(posedge clk);
        #1;
        bp_rand = ($urandom_range(0, 3) != 0);
    end

    pe_stu_packetizer #(
        .FIFO_DEPTH (4),
        .MAX_BEATS  (MAX_B)
    ) dut (
        .clk                   (clk),
        .reset_poweron_n       (reset_poweron_n),
        .sop__pkt__valid       (sop_valid),
        .sop__pkt__data        (sop_data),
        .sop__pkt__last        (sop_last),
        .sop__pkt__type        (sop_type),
        .sop__pkt__tag         (sop_tag),
        .pkt__sop__ready       (sop_ready),
        .pe__stu__valid        (stu_valid),
        .pe__stu__cntl         (stu_cntl),
        .pe__stu__type         (stu_type),
        .pe__stu__data         (stu_data),
        .pe__stu__oob_data     (stu_oob),
        .stu__pe__ready        (stu_ready),
        .sys__pkt__clear_error (clear_err),
        .pkt__sys__error       (sys_err),
        .pkt__sys__idle        (sys_idle)
    );

    typedef struct packed {
        logic [1:0]  cntl;
        logic [1:0]  ty;
        logic [63:0] data;
        logic [15:0] oob;
    } exp_beat_t;

    exp_beat_t exp_q[$];
    bit        exp_err;
    int        checks;
    int        errors;
    int        words_accepted;

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Packet-level reference: words pair low-first, an odd tail is a half
    // beat, and anything past 2*MAX_B words is cut at MAX_B beats.
    task automatic model_packet(input logic [31:0] w[$], input logic [1:0] ty, input logic [14:0] tg);
        int        n;
        int        nb;
        bit        ovr;
        bit        has_hi;
        bit        som;
        bit        eom;
        exp_beat_t e;
        n   = w.size();
        ovr = (n > 2 * MAX_B);
        nb  = ovr ? MAX_B : (n + 1) / 2;
        for (int b = 0; b < nb; b++) begin
            has_hi = (2 * b + 1 < n);
            som    = (b == 0);
            eom    = (b == nb - 1);
            e.cntl = (som && eom) ? 2'b11 : som ? 2'b01 : eom ? 2'b10 : 2'b00;
            e.ty   = ty;
            e.data = has_hi ? {w[2*b+1], w[2*b]} : {32'h0, w[2*b]};
            e.oob  = {tg, !has_hi};
            exp_q.push_back(e);
        end
        if (ovr) exp_err = 1'b1;
    endtask

    // Every valid beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset_poweron_n === 1'b1 && stu_valid === 1'b1) begin
            check("beat_present", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
                check("beat", {stu_cntl, stu_type, stu_data, stu_oob}, exp_q[0]);
                if (stu_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input bit last, input logic [1:0] ty, input logic [14:0] tg);
        int waited;
        waited    = 0;
        sop_valid = 1'b1;
        sop_data  = d;
        sop_last  = last;
        sop_type  = ty;
        sop_tag   = tg;
        @(negedge clk);
        while (sop_ready !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("accept_wait", (waited < 300), 1'b1);
        @(posedge clk);
        #1;
        words_accepted++;
        sop_valid = 1'b0;
        sop_last  = 1'b0;
    endtask

    task automatic send_packet(input logic [31:0] w[$], input logic [1:0] ty, input logic [14:0] tg, input int max_gap);
        int gap;
        for (int i = 0; i < w.size(); i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send_word(w[i], (i == w.size() - 1), ty, tg);
        end
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || sys_idle !== 1'b1) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_drain"}, (cyc < 400), 1'b1);
        check({name, "_idle"}, sys_idle, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        exp_err   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [31:0] w[$];
        logic [1:0]  ty;
        logic [14:0] tg;
        int          n;

        reset_poweron_n = 1'b0;
        sop_valid       = 1'b0;
        sop_data        = '0;
        sop_last        = 1'b0;
        sop_type        = '0;
        sop_tag         = '0;
        clear_err       = 1'b0;
        bp_mode         = 1'b0;
        forced_ready    = 1'b1;
        exp_err         = 1'b0;
        checks          = 0;
        errors          = 0;
        words_accepted  = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", stu_valid, 1'b0);
        check("rst_cntl", stu_cntl, 2'b00);
        check("rst_type", stu_type, 2'b00);
        check("rst_data", stu_data, 64'h0);
        check("rst_oob", stu_oob, 16'h0);
        check("rst_ready", sop_ready, 1'b1);
        check("rst_error", sys_err, 1'b0);
        check("rst_idle", sys_idle, 1'b1);
        reset_poweron_n = 1'b1;
        @(posedge clk);
        #1;

        // Four words, two full beats; first beat visible one cycle after A1.
        w = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
        model_packet(w, 2'b01, 15'h12);
        send_word(w[0], 1'b0, 2'b01, 15'h12);
        check("t1_no_beat_yet", stu_valid, 1'b0);
        send_word(w[1], 1'b0, 2'b01, 15'h12);
        check("t1_first_valid", stu_valid, 1'b1);
        check("t1_first_cntl", stu_cntl, 2'b01);
        check("t1_first_oob", stu_oob, 16'h0024);
        send_word(w[2], 1'b0, 2'b01, 15'h12);
        send_word(w[3], 1'b1, 2'b01, 15'h12);
        wait_drain("t1");

        // Single word packet.
        w = '{32'hDEAD_BEEF};
        model_packet(w, 2'b10, 15'h3ABC);
        send_word(w[0], 1'b1, 2'b10, 15'h3ABC);
        check("t2_valid", stu_valid, 1'b1);
        check("t2_data", stu_data, 64'h0000_0000_DEAD_BEEF);
        check("t2_cntl", stu_cntl, 2'b11);
        check("t2_half", stu_oob[0], 1'b1);
        wait_drain("t2");

        // Three words: full SOM beat then half EOM beat.
        w = '{32'h1111_0001, 32'h1111_0002, 32'h1111_0003};
        model_packet(w, 2'b11, 15'h0001);
        send_packet(w, 2'b11, 15'h0001, 0);
        wait_drain("t3");

        // Back-pressure: upstream stalled while a 12-word packet streams in.
        w.delete();
        for (int i = 0; i < 12; i++) w.push_back(32'hB000_0000 + i);
        model_packet(w, 2'b00, 15'h0555);
        forced_ready   = 1'b0;
        words_accepted = 0;
        fork
            send_packet(w, 2'b00, 15'h0555, 0);
            begin
                repeat (10) @(negedge clk);
                check("bp_ready_low", sop_ready, 1'b0);
                check("bp_words_in", words_accepted, 8);
                check("bp_valid_held", stu_valid, 1'b1);
                @(posedge clk);
                #1;
                forced_ready = 1'b1;
            end
        join
        wait_drain("t4");

        // Overrun: 20 words against an 8-beat limit.
        w.delete();
        for (int i = 0; i < 20; i++) w.push_back(32'hC000_0000 + i);
        model_packet(w, 2'b01, 15'h0077);
        send_packet(w, 2'b01, 15'h0077, 0);
        wait_drain("t5");
        check("ovr_error_set", sys_err, 1'b1);
        pulse_clear();
        check("ovr_error_clear", sys_err, 1'b0);

        // Reset mid-packet: ODD with two beats queued, then a fresh packet.
        w.delete();
        for (int i = 0; i < 8; i++) w.push_back(32'hD000_0000 + i);
        model_packet(w, 2'b10, 15'h0101);
        forced_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_word(w[i], 1'b0, 2'b10, 15'h0101);
        check("mid_valid_before", stu_valid, 1'b1);
        reset_poweron_n = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        #1;
        check("mid_rst_valid", stu_valid, 1'b0);
        check("mid_rst_idle", sys_idle, 1'b1);
        @(posedge clk);
        #1;
        reset_poweron_n = 1'b1;
        forced_ready    = 1'b1;
        @(posedge clk);
        #1;
        w = '{32'hE000_0000, 32'hE000_0001, 32'hE000_0002, 32'hE000_0003};
        model_packet(w, 2'b01, 15'h0202);
        send_word(w[0], 1'b0, 2'b01, 15'h0202);
        send_word(w[1], 1'b0, 2'b01, 15'h0202);
        check("after_rst_som", stu_cntl, 2'b01);
        send_word(w[2], 1'b0, 2'b01, 15'h0202);
        send_word(w[3], 1'b1, 2'b01, 15'h0202);
        wait_drain("t6");

        // Randomised packets under random upstream back-pressure.
        bp_mode = 1'b1;
        for (int p = 0; p < 25; p++) begin
            n  = $urandom_range(1, 20);
            ty = 2'($urandom_range(0, 3));
            tg = 15'($urandom);
            w.delete();
            for (int i = 0; i < n; i++) w.push_back($urandom);
            model_packet(w, ty, tg);
            send_packet(w, ty, tg, 2);
            wait_drain("rnd");
            check("rnd_error", sys_err, exp_err);
            if ($urandom_range(0, 1) == 1) begin
                pulse_clear();
                check("rnd_error_clear", sys_err, 1'b0);
            end
        end
        bp_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_stu_packetizer.md
Name: pe_stu_packetizer

Overview:
- Sits between the PE streaming-op result path and the stack-bus upstream (stu) port.
- Accepts a stream of 32-bit result words, each tagged with a last flag, and packs word pairs into 64-bit upstream beats.
- Frames each beat with SOM/MOM/EOM control, type and out-of-band tag, and buffers beats in a small FIFO under stu__pe__ready back-pressure.
- Enforces a maximum packet length; an overrun is a sticky error.

Parameters:
WORD_W, 32, result word width
DATA_W, 64, upstream data width (= 2*WORD_W, fixed ratio)
OOB_W, 16, upstream oob width; [OOB_W-1:1] = tag, [0] = half-beat flag
FIFO_DEPTH, 4, beat FIFO entries (power of 2, >=2)
MAX_BEATS, 64, maximum beats per packet

Ports:
clk  input  1  clock
reset_poweron_n  input  1  asynchronous active-low reset
sop__pkt__valid  input  1  result word valid
sop__pkt__data  input  WORD_W  result word
sop__pkt__last  input  1  word is last of packet
sop__pkt__type  input  2  packet type, sampled on first word
sop__pkt__tag  input  OOB_W-1  packet tag, sampled on first word
pkt__sop__ready  output  1  word accepted when valid&ready
pe__stu__valid  output  1  beat valid
pe__stu__cntl  output  2  framing
pe__stu__type  output  2  packet type
pe__stu__data  output  DATA_W  beat data
pe__stu__oob_data  output  OOB_W  {tag, half}
stu__pe__ready  input  1  upstream accepts beat when valid&ready
sys__pkt__clear_error  input  1  clears sticky error
pkt__sys__error  output  1  sticky max-length overrun
pkt__sys__idle  output  1  state IDLE and FIFO empty

Behaviour:
- Reset (async, active-low):
  - All outputs 0 except pkt__sop__ready=1 and pkt__sys__idle=1.
  - FIFO emptied, state IDLE, partial word and counters cleared.
  - Reset mid-packet discards the packet; no EOM is emitted.
- Cntl encoding (package): MOM=2'b00, SOM=2'b01, EOM=2'b10, SOM_EOM=2'b11.
- Word accept: a word is accepted when valid&ready.
  - pkt__sop__ready = !fifo_full || state==DRAIN.
  - When full, ready is 0 even if the accepted word would not complete a beat (conservative, simple).
- FSM states: IDLE, EVEN (in packet, no partial word held), ODD (low word held), DRAIN.
  - IDLE + accept: latch type/tag, first=1.
    - If last: push one-word beat {0,word}, half=1, cntl SOM_EOM; stay IDLE.
    - Else: hold word; go to ODD.
  - EVEN + accept:
    - If last: push half beat with EOM (or SOM_EOM if first); go to IDLE.
    - Else: hold word; go to ODD.
  - ODD + accept: push {word, held}, half=0.
    - cntl = SOM if first, else MOM; EOM/SOM_EOM if last.
    - Next state: last ? IDLE : EVEN.
  - Each push clears first and increments beat_cnt.
  - Overrun: if the push is beat number MAX_BEATS and last=0, force EOM, set pkt__sys__error, go to DRAIN.
  - DRAIN: accept and discard words, push nothing; on a last word go to IDLE.
- Latency: beat pushed in cycle t is visible on pe__stu__* in cycle t+1 when the FIFO was empty.
- FIFO output is registered; valid/cntl/data/type/oob stay stable while valid&!ready. No bubbles between back-to-back beats.
- Simultaneous push and pop with the FIFO full is not possible (ready gating). Push and pop in the same cycle is allowed at any other occupancy.
- Error: set and clear in the same cycle -> set wins. Error does not stop traffic.
- beat_cnt is 7 bits (clog2(MAX_BEATS)+1) and cleared on IDLE entry. Wrap is not possible.

Decomposition:
- Package pe_stu_pkg: cntl encodings, stu type enum, beat struct {cntl, type, data, oob}, FSM enum.
- Sub-module: pe_stu_beat_fifo (generic sync FIFO, registered output, full/empty, parameterised depth/width).

Test Plan:
- 4 words A0..A3, last on A3, type=2'b01, tag=0x12, ready=1 -> beats {A1,A0} SOM and {A3,A2} EOM, oob=0x24; first valid one cycle after A1 accepted.
- Single word 0xDEADBEEF with last -> one beat, data 0x00000000_DEADBEEF, cntl SOM_EOM, oob[0]=1.
- 3 words, last on word 3 -> beat 1 SOM, beat 2 {0,W2} EOM with half=1.
- stu__pe__ready=0 for 10 cycles during a 12-word packet -> FIFO fills to 4, pkt__sop__ready drops, held beat stable, no loss or duplication after release.
- MAX_BEATS=4, 12-word packet -> 4 beats with the 4th EOM, error=1, remaining 4 words drained, idle=1; clear_error -> error=0.
- Reset asserted mid-packet (state ODD, FIFO holding 2 beats) -> valid=0 immediately; the next packet starts with SOM.
